// File: rtl/wrb.sv
// -----------------------------------------------------------------------------
// wrb : weight register bank
//
// Double-buffered weight storage between the weight memory controller and the
// MAC array. The memory controller streams one channel's weights into the
// shadow bank. When the compute controller requests a swap and the shadow bank
// is complete, the shadow bank is copied into the active bank. The active bank
// drives the MAC array. The next channel can then load while the current one
// is convolved.
//
// Handshakes:
//   Write  : WRB_Muxes_En is a one-cycle strobe with no back-pressure. A write
//            that cannot be accepted is dropped and sets the sticky WRB_Error.
//   Swap   : WRB_Swap is a level request held until WRB_Swap_Ack. The ack is a
//            one-cycle pulse on the edge that performs the transfer.
//
// Ports:
//   WRB_Clk          in   clock, rising edge
//   WRB_Reset        in   asynchronous active-low reset
//   WRB_Input_Data   in   weight data
//   WRB_Muxes_En     in   write strobe
//   WRB_Muxes_Sel    in   target register index
//   WRB_Count        in   last valid index of the channel, sampled at first write
//   WRB_Swap         in   swap request (level)
//   WRB_Shadow_Full  out  shadow bank holds a complete channel
//   WRB_Active_Valid out  active bank holds valid weights
//   WRB_Swap_Ack     out  one-cycle pulse when a transfer is done
//   WRB_Error        out  sticky dropped-write flag
//   WRB_Weights      out  active bank, entry i at [i*W_DATA_WIDTH +: W_DATA_WIDTH]
// -----------------------------------------------------------------------------
module wrb #(
  parameter int W_DATA_WIDTH = 8,
  parameter int W_ADDR_WIDTH = 9,
  parameter int W_REGS       = 16
) (
  input  logic                           WRB_Clk,
  input  logic                           WRB_Reset,
  input  logic [W_DATA_WIDTH-1:0]        WRB_Input_Data,
  input  logic                           WRB_Muxes_En,
  input  logic [W_ADDR_WIDTH-1:0]        WRB_Muxes_Sel,
  input  logic [W_ADDR_WIDTH-1:0]        WRB_Count,
  input  logic                           WRB_Swap,
  output logic                           WRB_Shadow_Full,
  output logic                           WRB_Active_Valid,
  output logic                           WRB_Swap_Ack,
  output logic                           WRB_Error,
  output logic [W_REGS*W_DATA_WIDTH-1:0] WRB_Weights
);

  localparam int IDX_W = (W_REGS > 1) ? $clog2(W_REGS) : 1;
  localparam logic [W_ADDR_WIDTH-1:0] REGS_LIM = W_ADDR_WIDTH'(W_REGS);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } shadow_state_e;

  shadow_state_e state_q, state_d;
  logic [W_REGS-1:0]       mask_q, mask_d;
  logic [W_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [W_DATA_WIDTH-1:0] shadow_q [W_REGS];
  logic [W_DATA_WIDTH-1:0] active_q [W_REGS];
  logic                    active_valid_q;
  logic                    ack_q;
  logic                    error_q;

  logic                    take_swap;
  logic                    fresh;
  logic                    write_ok;
  logic                    all_set;
  logic [W_ADDR_WIDTH-1:0] cnt_eff;
  logic [W_REGS-1:0]       sel_onehot;
  logic [IDX_W-1:0]        sel_idx;

  assign sel_idx = WRB_Muxes_Sel[IDX_W-1:0];

  // Next-state logic. "fresh" means the write this cycle (if any) starts a
  // new fill: either the shadow is empty, or it is being swapped out on this
  // very edge. A fresh write uses the incoming count and a cleared mask.
  always_comb begin
    take_swap  = WRB_Swap && (state_q == FULL);
    fresh      = (state_q == EMPTY) || take_swap;
    cnt_eff    = fresh ? WRB_Count : cnt_q;
    write_ok   = 1'b0;
    sel_onehot = '0;
    all_set    = 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (fresh) begin
      write_ok = WRB_Muxes_En && (WRB_Count < REGS_LIM) && (WRB_Muxes_Sel <= WRB_Count);
    end else begin
      write_ok = WRB_Muxes_En && (state_q == FILLING) && (WRB_Muxes_Sel <= cnt_q);
    end

    if (write_ok) begin
      sel_onehot[sel_idx] = 1'b1;
    end

    mask_d = (fresh ? '0 : mask_q) | sel_onehot;

    // Completion is judged on the post-write mask so that Shadow_Full rises on
    // the same edge that captures the last missing entry.
    for (int i = 0; i < W_REGS; i++) begin
      if ((W_ADDR_WIDTH'(i) <= cnt_eff) && !mask_d[i]) begin
        all_set = 1'b0;
      end
    end

    if (fresh) begin
      if (write_ok) begin
        cnt_d   = WRB_Count;
        state_d = all_set ? FULL : FILLING;
      end else begin
        state_d = EMPTY;
      end
    end else if (state_q == FILLING) begin
      if (all_set) begin
        state_d = FULL;
      end
    end else if (state_q != FULL) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge WRB_Clk or negedge WRB_Reset) begin
    if (!WRB_Reset) begin
      state_q        <= EMPTY;
      mask_q         <= '0;
      cnt_q          <= '0;
      active_valid_q <= 1'b0;
      ack_q          <= 1'b0;
      error_q        <= 1'b0;
      for (int i = 0; i < W_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ack_q   <= take_swap;

      // Transfer reads the pre-edge shadow, so a write on the swap edge
      // lands only in the new fill.
      if (take_swap) begin
        active_valid_q <= 1'b1;
        for (int i = 0; i < W_REGS; i++) begin
          active_q[i] <= (W_ADDR_WIDTH'(i) <= cnt_q) ? shadow_q[i] : '0;
        end
      end

      if (write_ok) begin
        shadow_q[sel_idx] <= WRB_Input_Data;
      end

      if (WRB_Muxes_En && !write_ok) begin
        error_q <= 1'b1;
      end
    end
  end

  assign WRB_Shadow_Full  = (state_q == FULL);
  assign WRB_Active_Valid = active_valid_q;
  assign WRB_Swap_Ack     = ack_q;
  assign WRB_Error        = error_q;

  for (genvar g = 0; g < W_REGS; g++) begin : g_weights
    assign WRB_Weights[g*W_DATA_WIDTH +: W_DATA_WIDTH] = active_q[g];
  end

endmodule

// File: doc/wrb.md
# wrb

Weight register bank: the stage directly downstream of the on-chip weight memory controller. It captures the per-channel weight stream (data plus mux enable/select) into a shadow bank. On request it transfers a completely filled shadow bank into an active bank, which drives the MAC array. This double-buffering lets channel N+1 load while channel N is being convolved.

## Interface
- W_DATA_WIDTH, 8, width of one weight
- W_ADDR_WIDTH, 9, width of mux select and count inputs
- W_REGS, 16, number of weight registers per bank (maximum COXRW)

- WRB_Clk  in  1  system clock; all state updates on its rising edge
- WRB_Reset  in  1  reset, asynchronous, active-low
- WRB_Input_Data  in  W_DATA_WIDTH  weight from the memory controller output data
- WRB_Muxes_En  in  1  write strobe from the memory controller
- WRB_Muxes_Sel  in  W_ADDR_WIDTH  target register index
- WRB_Count  in  W_ADDR_WIDTH  last valid index (COXRW-1); sampled at the first write of each fill
- WRB_Swap  in  1  level request from the compute controller; held until WRB_Swap_Ack
- WRB_Shadow_Full  out  1  shadow bank holds a complete channel
- WRB_Active_Valid  out  1  active bank holds valid weights
- WRB_Swap_Ack  out  1  one-cycle pulse; transfer done
- WRB_Error  out  1  sticky; a write was dropped
- WRB_Weights  out  W_REGS*W_DATA_WIDTH  active bank, flattened; entry i occupies bits [i*W_DATA_WIDTH +: W_DATA_WIDTH]

## Operation
- Shadow FSM has three states: EMPTY, FILLING, FULL. The state drives WRB_Shadow_Full, which equals (state==FULL).
- A per-entry written mask, mask[W_REGS-1:0], is cleared on entering EMPTY.
- EMPTY, on a valid write:
  - latch WRB_Count into cnt_q;
  - store the data and set the mask bit;
  - go to FILLING, or to FULL if cnt_q==0.
- Valid write: En=1 and Sel<=cnt_q and Sel<W_REGS. In EMPTY, the incoming WRB_Count is used in place of cnt_q.
- Write with En=1 that is not valid: data dropped, WRB_Error set.
- WRB_Count >= W_REGS at latch time: the write is dropped, WRB_Error is set, and the state stays EMPTY.
- FILLING, on a valid write: store the data and set the mask bit. Rewriting an index already written overwrites it and is not an error.
- FILLING to FULL: on the edge after which mask[0..cnt_q] are all set.
- FULL, En=1 without a swap that cycle: overrun. Data dropped, WRB_Error set, state unchanged.
- Swap: taken on the edge where WRB_Swap=1 and state==FULL. On that edge:
  - active[i] <= shadow[i] for i<=cnt_q;
  - active[i] <= 0 for i>cnt_q;
  - WRB_Active_Valid <= 1;
  - WRB_Swap_Ack <= 1 for one cycle;
  - shadow goes to EMPTY and the mask clears.
- WRB_Swap=1 while not FULL: no action. The request stays pending and is taken on the first edge at which the state is FULL.
- Swap and En=1 on the same edge: the swap uses the pre-edge shadow contents. The write is then treated as the first write of the new fill: WRB_Count is latched, the state goes EMPTY→FILLING (or FULL if WRB_Count==0), and only that entry's mask bit is set.
- WRB_Active_Valid stays 1 after the first swap until reset. The active bank changes only at a swap.
- WRB_Error clears only on reset.

## Timing
- Reset (WRB_Reset=0, asynchronous) forces:
  - both banks to 0 and the mask to 0;
  - state to EMPTY, cnt_q to 0;
  - WRB_Shadow_Full, WRB_Active_Valid, WRB_Swap_Ack and WRB_Error to 0;
  - WRB_Weights to all zeros.
- Reset asserted mid-fill or mid-swap: everything is lost and no ack is issued. Operation resumes on the first rising edge after release.
- Write latency: data present in shadow one edge after sampling. WRB_Shadow_Full rises on the same edge that captures the last missing entry.
- Swap latency: WRB_Weights, WRB_Active_Valid and WRB_Swap_Ack all update on the swap edge. The requester drops WRB_Swap on the cycle it sees the ack.
- If WRB_Swap is still high after the ack, a second swap occurs only once the shadow is FULL again.
- Throughput: one write per cycle. A new channel can complete a fill in cnt_q+1 cycles after a swap, including the write on the swap cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset check: pulse WRB_Reset low mid-cycle → all outputs 0 immediately (asynchronously), WRB_Weights=0.
- Basic fill and swap, Count=3:
  - write 10,20,30,40 to Sel 0..3 on consecutive cycles → WRB_Shadow_Full=1 after the 4th edge;
  - assert Swap → next edge entries 0..3 = 10,20,30,40, entries 4..15 = 0, Ack pulses one cycle, Active_Valid=1, Shadow_Full=0.
- Early swap request, Count=2: raise Swap before any writes, then write 5,6,7 to Sel 0..2 → the swap is taken on the edge after the write of 7 completes the fill (ack one cycle after Shadow_Full rises); active entries 0..2 = 5,6,7.
- Overrun and range errors:
  - write Sel=4 with Count=3 → dropped, Error=1;
  - fill completely, then write again without a swap → dropped, shadow unchanged, Error stays 1.
- Simultaneous swap and write: with shadow FULL (values 1,2,3,4) and Swap=1, also write 99 to Sel 0 → active = 1,2,3,4; the new fill is in FILLING with shadow[0]=99 and only mask bit 0 set.
- Reset mid-fill: write 2 of 4 entries, assert reset → shadow is EMPTY. A fresh 4-write fill then sets Shadow_Full only after all 4 writes.
